// File: rtl/ham_encoder_tx.sv
// Hamming(7,4) encoder with a one-deep holding register and an LSB-first serializer.
// Parity sits at codeword bits 0, 1 and 3; data sits at bits 2, 4, 5 and 6.
module ham_encoder_tx (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [3:0]  i_data,
  input  logic        i_dataValid,
  output logic        o_dataReady,
  input  logic [2:0]  i_errPos,
  output logic        o_serialOut,
  output logic        o_serialValid,
  output logic [6:0]  o_codeword,
  output logic [15:0] o_sentCount
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [6:0]  r_hold;
  logic        r_holdFull;
  logic [6:0]  r_shift;
  logic [2:0]  r_bitCnt;
  logic [15:0] r_sentCount;
  logic        w_accept;
  logic        w_load;
  logic        w_lastBit;

  function automatic logic [6:0] encode_fn(input logic [3:0] d);
    logic [6:0] cw;
    cw[0] = d[0] ^ d[1] ^ d[3];
    cw[1] = d[0] ^ d[2] ^ d[3];
    cw[2] = d[0];
    cw[3] = d[1] ^ d[2] ^ d[3];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    return cw;
  endfunction

  // errPos is the 1-indexed Hamming position, so the receiver's syndrome equals it.
  function automatic logic [6:0] inject_fn(input logic [6:0] cw, input logic [2:0] pos);
    if (pos == 3'd0) return cw;
    return cw ^ (7'd1 << (pos - 3'd1));
  endfunction

  assign w_accept  = i_dataValid && !r_holdFull;
  assign w_lastBit = (r_bitCnt == 3'd6);

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_holdFull) begin
          w_nextState = S_SEND;
          w_load      = 1'b1;
        end
      end
      S_SEND: begin
        if (w_lastBit) begin
          if (r_holdFull) w_load      = 1'b1;
          else            w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    o_dataReady   = !r_holdFull;
    o_serialValid = (r_state == S_SEND);
    o_serialOut   = (r_state == S_SEND) ? r_shift[r_bitCnt] : 1'b0;
    o_codeword    = r_shift;
    o_sentCount   = r_sentCount;
  end

  // Accept and drain are mutually exclusive: accept needs !holdFull, load needs holdFull.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hold      <= 7'd0;
      r_holdFull  <= 1'b0;
      r_shift     <= 7'd0;
      r_bitCnt    <= 3'd0;
      r_sentCount <= 16'd0;
    end else begin
      if (w_accept) begin
        r_hold     <= inject_fn(encode_fn(i_data), i_errPos);
        r_holdFull <= 1'b1;
      end else if (w_load) begin
        r_holdFull <= 1'b0;
      end

      if (w_load) begin
        r_shift  <= r_hold;
        r_bitCnt <= 3'd0;
      end else if (r_state == S_SEND) begin
        r_bitCnt <= r_bitCnt + 3'd1;
      end

      if ((r_state == S_SEND) && w_lastBit)
        r_sentCount <= r_sentCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_ham_encoder_tx.sv
// Bench for ham_encoder_tx: directed and random nibbles, serial capture, and a
// position-based Hamming reference encoder/decoder.
module tb_ham_encoder_tx;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [3:0]  i_data;
  logic        i_dataValid;
  logic        o_dataReady;
  logic [2:0]  i_errPos;
  logic        o_serialOut;
  logic        o_serialValid;
  logic [6:0]  o_codeword;
  logic [15:0] o_sentCount;

  always #5 clk = ~clk;

  ham_encoder_tx dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_data       (i_data),
    .i_dataValid  (i_dataValid),
    .o_dataReady  (o_dataReady),
    .i_errPos     (i_errPos),
    .o_serialOut  (o_serialOut),
    .o_serialValid(o_serialValid),
    .o_codeword   (o_codeword),
    .o_sentCount  (o_sentCount)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] rx_words[$];
  logic [6:0] acc;
  int         accn   = 0;
  int         nbits  = 0;
  int         run    = 0;
  int         maxrun = 0;

  // Serial capture: rebuild codewords LSB first and track the longest valid run.
  always @(negedge clk) begin
    if (i_reset) begin
      accn = 0;
      run  = 0;
    end else if (o_serialValid) begin
      acc[accn] = o_serialOut;
      accn++;
      nbits++;
      run++;
      if (run > maxrun) maxrun = run;
      if (accn == 7) begin
        rx_words.push_back(acc);
        accn = 0;
      end
    end else begin
      run = 0;
    end
  end

  // Reference encoder: data in the non-power-of-two positions 3,5,6,7; each
  // parity position p zeroes the XOR over all positions whose index has bit p set.
  function automatic logic [6:0] enc_ref(input logic [3:0] d, input int e);
    logic [6:0] cw;
    int dpos[4];
    int par;
    dpos = '{3, 5, 6, 7};
    cw = 7'd0;
    for (int i = 0; i < 4; i++) cw[dpos[i]-1] = d[i];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 0;
      for (int i = 1; i <= 7; i++)
        if (((i & p) != 0) && (i != p)) par = par ^ int'(cw[i-1]);
      cw[p-1] = par[0];
    end
    if (e != 0) cw[e-1] = ~cw[e-1];
    return cw;
  endfunction

  function automatic int syndrome(input logic [6:0] w);
    int s;
    s = 0;
    for (int i = 1; i <= 7; i++) if (w[i-1]) s = s ^ i;
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_dataValid = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic send(input logic [3:0] d, input logic [2:0] e, input bit keep);
    int t;
    t = 0;
    i_data = d;
    i_errPos = e;
    i_dataValid = 1'b1;
    while (!o_dataReady && t < 50) begin
      tick();
      t++;
    end
    check("ready_wait", 32'(t < 50), 32'd1);
    tick();
    if (!keep) i_dataValid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(o_dataReady && !o_serialValid) && t < 200) begin
      tick();
      t++;
    end
    check("idle_wait", 32'(t < 200), 32'd1);
  endtask

  initial begin
    int base;
    int snap;
    int syn;
    logic [6:0] w;
    logic [6:0] corr;
    logic [6:0] exp_q[$];
    logic [15:0] exp_count;
    logic [3:0] rd;
    logic [2:0] re;

    i_reset = 1'b1;
    i_data = 4'd0;
    i_errPos = 3'd0;
    i_dataValid = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;

    // Idle after reset
    check("reset_codeword", 32'(o_codeword), 32'h0);
    for (int i = 0; i < 10; i++) begin
      check("idle_ready", 32'(o_dataReady), 32'd1);
      check("idle_valid", 32'(o_serialValid), 32'd0);
      check("idle_out", 32'(o_serialOut), 32'd0);
      check("idle_count", 32'(o_sentCount), 32'd0);
      tick();
    end

    // Single codeword 1011 with latency check
    do_reset();
    base = rx_words.size();
    send(4'b1011, 3'd0, 1'b0);
    check("lat_e0_valid", 32'(o_serialValid), 32'd0);
    tick();
    check("lat_e1_valid", 32'(o_serialValid), 32'd1);
    check("lat_e1_bit0", 32'(o_serialOut), 32'(enc_ref(4'b1011, 0) & 7'd1));
    wait_idle();
    check("cw_1011", 32'(o_codeword), 32'h55);
    check("cw_1011_model", 32'(o_codeword), 32'(enc_ref(4'b1011, 0)));
    check("rx_1011", 32'(rx_words[base]), 32'h55);
    check("count_1011", 32'(o_sentCount), 32'd1);

    // Back-to-back 0, F, 1 with dataValid held
    do_reset();
    maxrun = 0;
    base = rx_words.size();
    send(4'h0, 3'd0, 1'b1);
    check("b2b_ready_low0", 32'(o_dataReady), 32'd0);
    send(4'hF, 3'd0, 1'b1);
    check("b2b_ready_low1", 32'(o_dataReady), 32'd0);
    send(4'h1, 3'd0, 1'b0);
    wait_idle();
    check("b2b_nwords", 32'(rx_words.size() - base), 32'd3);
    check("b2b_w0", 32'(rx_words[base]),   32'h00);
    check("b2b_w1", 32'(rx_words[base+1]), 32'h7F);
    check("b2b_w2", 32'(rx_words[base+2]), 32'h07);
    check("b2b_run", 32'(maxrun), 32'd21);
    check("b2b_count", 32'(o_sentCount), 32'd3);
    exp_count = 16'd3;

    // Injection example: data 1, errPos 3
    send(4'h1, 3'd3, 1'b0);
    wait_idle();
    exp_count++;
    check("inj_cw", 32'(o_codeword), 32'h03);
    check("inj_rx", 32'(rx_words[rx_words.size()-1]), 32'h03);

    // All nibbles x all errPos through a reference decoder
    for (int d = 0; d < 16; d++) begin
      for (int e = 0; e < 8; e++) begin
        send(4'(d), 3'(e), 1'b0);
        wait_idle();
        exp_count++;
        w = rx_words[rx_words.size()-1];
        syn = syndrome(w);
        corr = (syn != 0) ? (w ^ (7'd1 << (syn - 1))) : w;
        check("sweep_syndrome", 32'(syn), 32'(e));
        check("sweep_corrected", 32'(corr), 32'(enc_ref(4'(d), 0)));
      end
    end

    // Random nibbles/errPos with random gaps
    base = rx_words.size();
    for (int i = 0; i < 40; i++) begin
      rd = 4'($urandom_range(15));
      re = 3'($urandom_range(7));
      exp_q.push_back(enc_ref(rd, int'(re)));
      send(rd, re, 1'b0);
      repeat ($urandom_range(3)) tick();
    end
    wait_idle();
    exp_count = exp_count + 16'd40;
    check("rand_nwords", 32'(rx_words.size() - base), 32'd40);
    for (int i = 0; i < 40; i++)
      if (base + i < rx_words.size())
        check("rand_word", 32'(rx_words[base+i]), 32'(exp_q[i]));
    check("rand_count", 32'(o_sentCount), 32'(exp_count));

    // Reset at the 4th serialized bit with hold full
    do_reset();
    send(4'h5, 3'd0, 1'b0);
    send(4'hA, 3'd0, 1'b0);
    check("mid_hold_full", 32'(o_dataReady), 32'd0);
    tick();
    tick();
    check("mid_sending", 32'(o_serialValid), 32'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("mid_valid", 32'(o_serialValid), 32'd0);
    check("mid_ready", 32'(o_dataReady), 32'd1);
    check("mid_count", 32'(o_sentCount), 32'd0);
    check("mid_out", 32'(o_serialOut), 32'd0);
    check("mid_codeword", 32'(o_codeword), 32'd0);
    snap = nbits;
    repeat (20) tick();
    check("mid_no_bits", 32'(nbits), 32'(snap));
    check("mid_count_after", 32'(o_sentCount), 32'd0);

    // sentCount wrap from FFFF
    force dut.r_sentCount = 16'hFFFF;
    tick();
    release dut.r_sentCount;
    send(4'h9, 3'd0, 1'b0);
    wait_idle();
    check("wrap_count", 32'(o_sentCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
